// File: rtl/bus_master_port_pkg.sv
// Shared bus constants: master FSM encoding and the slave-select frame format.
// The arbiter imports the same package so both ends agree on the frame layout.
package bus_master_port_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_ADDR    = 3'd2,
        ST_WRITE   = 3'd3,
        ST_READ    = 3'd4,
        ST_RELEASE = 3'd5
    } bus_state_e;

    localparam int   SLAVE_ID_W = 2;
    localparam int   FRAME_LEN  = 3;
    localparam logic START_BIT  = 1'b1;

    // Frame bits leave LSB first: start bit, then id[0], then id[1].
    function automatic logic [FRAME_LEN-1:0] slave_frame(input logic [SLAVE_ID_W-1:0] id);
        return {id[1], id[0], START_BIT};
    endfunction

endpackage

// File: rtl/bus_master_port_if.sv
// Core-side command and system-bus signals of one master port.
interface bus_master_port_if #(
    parameter int DATA_WIDTH = 8
) ();
    import bus_master_port_pkg::*;

    logic                  start;
    logic                  rw;
    logic [SLAVE_ID_W-1:0] slave_id;
    logic [DATA_WIDTH-1:0] wdata_in;
    logic                  request;
    logic                  grant;
    logic                  slave_select;
    logic                  mode;
    logic                  wdata;
    logic                  wvalid;
    logic                  rdata;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata_out;
    logic                  done;
    logic                  err;
    logic                  busy;

    modport master (
        input  start, rw, slave_id, wdata_in, grant, rdata, rvalid,
        output request, slave_select, mode, wdata, wvalid, rdata_out, done, err, busy
    );

    modport slave (
        output start, rw, slave_id, wdata_in, grant, rdata, rvalid,
        input  request, slave_select, mode, wdata, wvalid, rdata_out, done, err, busy
    );

endinterface

// File: rtl/bus_shift_reg.sv
// Word shift register shared by both transfer directions: parallel load,
// right shift with serial input at the MSB, and a count of shifts since load.
module bus_shift_reg #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] load_data_i,
    input  logic                  shift_i,
    input  logic                  sin_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [CNT_W-1:0]      count_o
);

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0]      count_q, count_d;

    always_comb begin
        data_d  = data_q;
        count_d = count_q;
        if (load_i) begin
            data_d  = load_data_i;
            count_d = '0;
        end else if (shift_i) begin
            data_d  = {sin_i, data_q[DATA_WIDTH-1:1]};
            count_d = count_q + CNT_W'(1);
        end
    end

    // NOTE: the data word is reset as well; it is only DATA_WIDTH flops and
    // keeps unknowns off wdata and rdata_out after power-up.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign data_o  = data_q;
    assign count_o = count_q;

endmodule

// File: rtl/bus_master_port.sv
// Master-side bus initiator: requests the bus, sends the slave-select frame,
// then moves one word serially to or from the selected slave.
module bus_master_port
    import bus_master_port_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 16,
    parameter int CNT_W      = 5
) (
    input  logic              clk,
    input  logic              reset,
    bus_master_port_if.master bus
);

    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] DW_LAST   = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] DW_FULL   = CNT_W'(DATA_WIDTH);

    bus_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  rw_q, rw_d;
    logic [SLAVE_ID_W-1:0] id_q, id_d;
    logic [FRAME_LEN-1:0]  addr_sh_q, addr_sh_d;
    logic                  request_q, request_d;
    logic                  busy_q, busy_d;
    logic                  slave_select_q, slave_select_d;
    logic                  mode_q, mode_d;
    logic                  wvalid_q, wvalid_d;
    logic                  wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_out_q, rdata_out_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  fin_ok, fin_err;
    logic [FRAME_LEN-1:0]  frame;
    logic                  sr_load, sr_shift, sr_sin;
    logic [DATA_WIDTH-1:0] sr_data;
    logic [CNT_W-1:0]      sr_count;

    bus_shift_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_W      (CNT_W)
    ) u_shift (
        .clk         (clk),
        .reset       (reset),
        .load_i      (sr_load),
        .load_data_i (bus.wdata_in),
        .shift_i     (sr_shift),
        .sin_i       (sr_sin),
        .data_o      (sr_data),
        .count_o     (sr_count)
    );

    // Outputs are computed one cycle ahead and registered; the done/err cycle
    // coincides with RELEASE, so request is already low there while busy is
    // still high, and busy drops on the way back to IDLE.
    always_comb begin
        // NOTE: every combinational output is defaulted first, so no path can infer a latch.
        state_d        = state_q;
        cnt_d          = cnt_q;
        rw_d           = rw_q;
        id_d           = id_q;
        addr_sh_d      = addr_sh_q;
        request_d      = request_q;
        busy_d         = busy_q;
        slave_select_d = 1'b0;
        mode_d         = 1'b0;
        wvalid_d       = 1'b0;
        wdata_d        = 1'b0;
        rdata_out_d    = rdata_out_q;
        done_d         = 1'b0;
        err_d          = 1'b0;
        fin_ok         = 1'b0;
        fin_err        = 1'b0;
        sr_load        = 1'b0;
        sr_shift       = 1'b0;
        sr_sin         = 1'b0;
        frame          = slave_frame(id_q);

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    rw_d      = bus.rw;
                    id_d      = bus.slave_id;
                    sr_load   = 1'b1;
                    cnt_d     = '0;
                    request_d = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.grant) begin
                    cnt_d          = '0;
                    slave_select_d = frame[0];
                    addr_sh_d      = frame >> 1;
                    state_d        = ST_ADDR;
                end else if (cnt_q == TO_LAST) begin
                    fin_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_ADDR: begin
                if (!bus.grant) begin
                    fin_err = 1'b1;
                end else if (cnt_q == ADDR_LAST) begin
                    cnt_d = '0;
                    if (rw_q) begin
                        mode_d   = 1'b1;
                        wvalid_d = 1'b1;
                        wdata_d  = sr_data[0];
                        sr_shift = 1'b1;
                        state_d  = ST_WRITE;
                    end else begin
                        state_d  = ST_READ;
                    end
                end else begin
                    cnt_d          = cnt_q + CNT_W'(1);
                    slave_select_d = addr_sh_q[0];
                    addr_sh_d      = addr_sh_q >> 1;
                end
            end
            ST_WRITE: begin
                if (!bus.grant) begin
                    fin_err = 1'b1;
                end else if (sr_count == DW_FULL) begin
                    fin_ok = 1'b1;
                end else begin
                    mode_d   = 1'b1;
                    wvalid_d = 1'b1;
                    wdata_d  = sr_data[0];
                    sr_shift = 1'b1;
                end
            end
            ST_READ: begin
                if (!bus.grant) begin
                    fin_err = 1'b1;
                end else if (bus.rvalid) begin
                    sr_shift = 1'b1;
                    sr_sin   = bus.rdata;
                    if (sr_count == DW_LAST) begin
                        rdata_out_d = {bus.rdata, sr_data[DATA_WIDTH-1:1]};
                        fin_ok      = 1'b1;
                    end
                end else if (sr_count == '0) begin
                    // The first-bit timeout only applies before any bit arrived.
                    if (cnt_q == TO_LAST) begin
                        fin_err = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_RELEASE: begin
                request_d = 1'b0;
                busy_d    = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                request_d = 1'b0;
                busy_d    = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase

        if (fin_ok || fin_err) begin
            done_d    = fin_ok;
            err_d     = fin_err;
            request_d = 1'b0;
            state_d   = ST_RELEASE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            rw_q           <= 1'b0;
            id_q           <= '0;
            addr_sh_q      <= '0;
            request_q      <= 1'b0;
            busy_q         <= 1'b0;
            slave_select_q <= 1'b0;
            mode_q         <= 1'b0;
            wvalid_q       <= 1'b0;
            wdata_q        <= 1'b0;
            rdata_out_q    <= '0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            rw_q           <= rw_d;
            id_q           <= id_d;
            addr_sh_q      <= addr_sh_d;
            request_q      <= request_d;
            busy_q         <= busy_d;
            slave_select_q <= slave_select_d;
            mode_q         <= mode_d;
            wvalid_q       <= wvalid_d;
            wdata_q        <= wdata_d;
            rdata_out_q    <= rdata_out_d;
            done_q         <= done_d;
            err_q          <= err_d;
        end
    end

    assign bus.request      = request_q;
    assign bus.busy         = busy_q;
    assign bus.slave_select = slave_select_q;
    assign bus.mode         = mode_q;
    assign bus.wvalid       = wvalid_q;
    assign bus.wdata        = wdata_q;
    assign bus.rdata_out    = rdata_out_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;

endmodule

// File: tb/tb_bus_master_port.sv
// Directed bench for bus_master_port: cycle tables for a write and a read,
// plus hand sequences for timeout, lost grant, start collision and reset.
module tb_bus_master_port;

    localparam int DW = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bus_master_port_if #(.DATA_WIDTH(DW)) bus ();

    bus_master_port #(
        .DATA_WIDTH (DW),
        .TIMEOUT    (16),
        .CNT_W      (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    typedef struct packed {
        logic        start;
        logic        rw;
        logic [1:0]  id;
        logic [7:0]  wd;
        logic        grant;
        logic        rdata;
        logic        rvalid;
        logic [15:0] exp_o;
    } vec_t;

    vec_t       vq[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_rout;

    // Expected output bundle: {request, slave_select, mode, wdata, wvalid, done, err, busy, rdata_out}
    function automatic logic [15:0] o(input logic req, ss, md, wd, wv, dn, er, bz,
                                      input logic [7:0] ro);
        return {req, ss, md, wd, wv, dn, er, bz, ro};
    endfunction

    function automatic logic [15:0] outs();
        return {bus.request, bus.slave_select, bus.mode, bus.wdata, bus.wvalid,
                bus.done, bus.err, bus.busy, bus.rdata_out};
    endfunction

    function automatic logic bit_of(input logic [7:0] w, input int i);
        logic [7:0] t;
        t = w >> i;
        return t[0];
    endfunction

    function automatic vec_t v(input logic st, rw, input logic [1:0] id, input logic [7:0] wd,
                               input logic g, rd, rv, input logic [15:0] e);
        vec_t r;
        r.start = st; r.rw = rw; r.id = id; r.wd = wd;
        r.grant = g; r.rdata = rd; r.rvalid = rv; r.exp_o = e;
        return r;
    endfunction

    task automatic drive(input logic st, rw, input logic [1:0] id, input logic [7:0] wd,
                         input logic g, rd, rv);
        bus.start = st; bus.rw = rw; bus.slave_id = id; bus.wdata_in = wd;
        bus.grant = g; bus.rdata = rd; bus.rvalid = rv;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] wword, rword, cword;
        logic [2:0] cframe;
        int fpos, nbits, ndone, nerr, lat;

        drive(0, 0, 2'd0, 8'h00, 0, 0, 0);
        exp_rout = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 32'(outs()), 32'(o(0,0,0,0,0,0,0,0, 8'h00)));
        reset = 1'b0;
        step();

        // Write: id=2, 0xA5, grant arrives on the third request cycle.
        wword = 8'hA5;
        vq.push_back(v(1,1,2'd2,8'hA5, 0,0,0, o(0,0,0,0,0,0,0,0, 8'h00)));
        vq.push_back(v(0,0,2'd0,8'h00, 0,0,0, o(1,0,0,0,0,0,0,1, 8'h00)));
        vq.push_back(v(0,0,2'd0,8'h00, 0,0,0, o(1,0,0,0,0,0,0,1, 8'h00)));
        vq.push_back(v(0,0,2'd0,8'h00, 1,0,0, o(1,0,0,0,0,0,0,1, 8'h00)));
        vq.push_back(v(0,0,2'd0,8'h00, 1,0,0, o(1,1,0,0,0,0,0,1, 8'h00)));
        vq.push_back(v(0,0,2'd0,8'h00, 1,0,0, o(1,0,0,0,0,0,0,1, 8'h00)));
        vq.push_back(v(0,0,2'd0,8'h00, 1,0,0, o(1,1,0,0,0,0,0,1, 8'h00)));
        for (int b = 0; b < 8; b++)
            vq.push_back(v(0,0,2'd0,8'h00, 1,0,0, o(1,0,1,bit_of(wword,b),1,0,0,1, 8'h00)));
        vq.push_back(v(0,0,2'd0,8'h00, 0,0,0, o(0,0,0,0,0,1,0,1, 8'h00)));
        vq.push_back(v(0,0,2'd0,8'h00, 0,0,0, o(0,0,0,0,0,0,0,0, 8'h00)));

        // Read: id=1, slave returns 0x3C with a one-cycle rvalid gap after bit 3.
        rword = 8'h3C;
        vq.push_back(v(1,0,2'd1,8'hFF, 0,0,0, o(0,0,0,0,0,0,0,0, 8'h00)));
        vq.push_back(v(0,0,2'd0,8'h00, 1,0,0, o(1,0,0,0,0,0,0,1, 8'h00)));
        vq.push_back(v(0,0,2'd0,8'h00, 1,0,0, o(1,1,0,0,0,0,0,1, 8'h00)));
        vq.push_back(v(0,0,2'd0,8'h00, 1,0,0, o(1,1,0,0,0,0,0,1, 8'h00)));
        vq.push_back(v(0,0,2'd0,8'h00, 1,0,0, o(1,0,0,0,0,0,0,1, 8'h00)));
        vq.push_back(v(0,0,2'd0,8'h00, 1,0,0, o(1,0,0,0,0,0,0,1, 8'h00)));
        for (int b = 0; b < 8; b++) begin
            if (b == 4)
                vq.push_back(v(0,0,2'd0,8'h00, 1,0,0, o(1,0,0,0,0,0,0,1, 8'h00)));
            vq.push_back(v(0,0,2'd0,8'h00, 1,bit_of(rword,b),1, o(1,0,0,0,0,0,0,1, 8'h00)));
        end
        vq.push_back(v(0,0,2'd0,8'h00, 0,0,0, o(0,0,0,0,0,1,0,1, 8'h3C)));
        vq.push_back(v(0,0,2'd0,8'h00, 0,0,0, o(0,0,0,0,0,0,0,0, 8'h3C)));

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].start, vq[i].rw, vq[i].id, vq[i].wd, vq[i].grant, vq[i].rdata, vq[i].rvalid);
            check($sformatf("vec%0d", i), 32'(outs()), 32'(vq[i].exp_o));
            step();
        end
        exp_rout = 8'h3C;

        // Grant never comes: sixteen request cycles, then err with request dropped.
        drive(1, 1, 2'd3, 8'h77, 0, 0, 0);
        step();
        drive(0, 0, 2'd0, 8'h00, 0, 0, 0);
        for (int k = 1; k <= 16; k++) begin
            check($sformatf("to_wait%0d", k), 32'(outs()), 32'(o(1,0,0,0,0,0,0,1, exp_rout)));
            step();
        end
        check("to_err", 32'(outs()), 32'(o(0,0,0,0,0,0,1,1, exp_rout)));
        step();
        check("to_idle", 32'(outs()), 32'(o(0,0,0,0,0,0,0,0, exp_rout)));

        // Grant withdrawn during write bit 4.
        wword = 8'h5A;
        drive(1, 1, 2'd3, 8'h5A, 1, 0, 0);
        step();
        drive(0, 0, 2'd0, 8'h00, 1, 0, 0);
        check("lg_req", 32'(outs()), 32'(o(1,0,0,0,0,0,0,1, exp_rout)));
        step();
        for (int a = 0; a < 3; a++) begin
            check($sformatf("lg_addr%0d", a), 32'(outs()), 32'(o(1,1,0,0,0,0,0,1, exp_rout)));
            step();
        end
        for (int b = 0; b < 5; b++) begin
            if (b == 4) bus.grant = 1'b0;
            check($sformatf("lg_bit%0d", b), 32'(outs()),
                  32'(o(1,0,1,bit_of(wword,b),1,0,0,1, exp_rout)));
            step();
        end
        check("lg_err", 32'(outs()), 32'(o(0,0,0,0,0,0,1,1, exp_rout)));
        step();
        check("lg_idle", 32'(outs()), 32'(o(0,0,0,0,0,0,0,0, exp_rout)));

        // Start pulsed while busy must not disturb the latched command.
        drive(1, 1, 2'd2, 8'hC3, 0, 0, 0);
        step();
        cword = 8'h00; cframe = 3'b000; fpos = -1; nbits = 0; ndone = 0; nerr = 0;
        for (int c = 1; c <= 20; c++) begin
            drive((c == 1 || c == 9), 0, 2'd1, 8'hFF, (c >= 3), 0, 0);
            if (fpos < 0 && bus.slave_select) fpos = 0;
            if (fpos >= 0 && fpos < 3) begin
                cframe = cframe | (3'(bus.slave_select) << fpos);
                fpos++;
            end
            if (bus.wvalid) begin
                if (nbits < 8) cword = cword | (8'(bus.wdata) << nbits);
                nbits++;
            end
            if (bus.done) ndone++;
            if (bus.err)  nerr++;
            step();
        end
        drive(0, 0, 2'd0, 8'h00, 0, 0, 0);
        check("col_frame", 32'(cframe), 32'(3'b101));
        check("col_word",  32'(cword),  32'(8'hC3));
        check("col_bits",  32'(nbits),  32'(8));
        check("col_done",  32'(ndone),  32'(1));
        check("col_err",   32'(nerr),   32'(0));
        check("col_idle",  32'(outs()), 32'(o(0,0,0,0,0,0,0,0, exp_rout)));

        // Reset in the middle of a read clears everything at once.
        drive(1, 0, 2'd0, 8'h00, 1, 0, 0);
        step();
        drive(0, 0, 2'd0, 8'h00, 1, 0, 0);
        repeat (4) step();
        for (int b = 0; b < 2; b++) begin
            drive(0, 0, 2'd0, 8'h00, 1, ~b[0], 1);
            step();
        end
        check("rst_pre", 32'(outs()), 32'(o(1,0,0,0,0,0,0,1, exp_rout)));
        reset = 1'b1;
        #1;
        exp_rout = 8'h00;
        check("rst_async", 32'(outs()), 32'(o(0,0,0,0,0,0,0,0, 8'h00)));
        #2;
        reset = 1'b0;
        drive(0, 0, 2'd0, 8'h00, 0, 0, 0);
        step();
        check("rst_idle", 32'(outs()), 32'(o(0,0,0,0,0,0,0,0, 8'h00)));

        // Fresh write after reset with grant already present: done 13 cycles after start.
        drive(1, 1, 2'd1, 8'h81, 1, 0, 0);
        lat = -1; ndone = 0; nerr = 0;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (c == 1) drive(0, 0, 2'd0, 8'h00, 1, 0, 0);
            if (bus.done) begin
                ndone++;
                if (lat < 0) lat = c;
            end
            if (bus.err) nerr++;
        end
        check("rst_new_latency", 32'(lat),   32'(13));
        check("rst_new_done",    32'(ndone), 32'(1));
        check("rst_new_err",     32'(nerr),  32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_master_port.md
Name: bus_master_port

Overview:
Master-side initiator for the shared system bus. It takes a single-transaction command from a local core and raises a bus request. Once granted, it serialises the slave-select frame that the arbiter decodes, then moves one DATA_WIDTH word serially to or from the selected slave. It releases the bus and reports completion or timeout to the core. One instance sits between each master core and the arbiter/master-select mux.

Parameters:
DATA_WIDTH, 8, width of one transferred word (serial, LSB first)
TIMEOUT, 16, max cycles waiting for grant or for first rvalid before abort
CNT_W, 5, counter width; must hold max(DATA_WIDTH, TIMEOUT)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle command strobe from core; sampled only in IDLE
rw  input  1  1 = write, 0 = read; latched with start
slave_id  input  2  target slave number; latched with start
wdata_in  input  DATA_WIDTH  write word; latched with start
request  output  1  bus request to arbiter
grant  input  1  this master's grant from arbiter
slave_select  output  1  serial slave-select frame line
mode  output  1  latched rw, driven during data phase, else 0
wdata  output  1  serial write data
wvalid  output  1  high while wdata carries a valid bit
rdata  input  1  serial read data from slave
rvalid  input  1  high while rdata carries a valid bit
rdata_out  output  DATA_WIDTH  assembled read word, held until next read completes
done  output  1  one-cycle pulse on successful completion
err  output  1  one-cycle pulse on timeout or lost grant
busy  output  1  high from accepted start until done/err cycle inclusive

Behaviour:
- Reset (async, active-high): state IDLE. All outputs 0, rdata_out = 0, counters cleared. Reset mid-transaction drops request the same instant.
- All outputs are registered.
- FSM states: IDLE, REQ, ADDR, WRITE, READ, RELEASE.
- IDLE: on start=1, latch rw/slave_id/wdata_in, set request=1 and busy=1, go REQ. start in any other state is ignored.
- REQ: count cycles with grant=0. On grant=1, go ADDR. When the count reaches TIMEOUT, pulse err and go RELEASE.
- ADDR: exactly 3 cycles driving slave_select = 1 (start bit), slave_id[0], slave_id[1]. Then slave_select=0.
  - The arbiter captures these into its slave grant as {id[1], id[0], 1}.
  - Next state: WRITE if rw, else READ.
- WRITE: mode=1, wvalid=1 for exactly DATA_WIDTH consecutive cycles, wdata = word bit i in cycle i. Then pulse done, go RELEASE.
- READ: mode=0. Wait for rvalid, timing out after TIMEOUT cycles (pulse err).
  - Each cycle with rvalid=1 shifts rdata into bit position count, LSB first.
  - rvalid low between bits stalls the count; no timeout applies after the first bit.
  - After DATA_WIDTH bits, update rdata_out with the full word (never a partial word) and pulse done.
- RELEASE: request=0, busy=0, mode=0, wvalid=0. Return to IDLE next cycle.
  - request stays low at least one cycle so the arbiter sees the bus free.
- Lost grant: grant=0 while in ADDR, WRITE or READ aborts. Pulse err, go RELEASE. rdata_out is unchanged.
- request stays high continuously from the cycle after start until RELEASE.
- done and err are mutually exclusive, and each fires exactly once per accepted start.
- Minimum write latency, start to done, is 1 + grant wait + 3 + DATA_WIDTH cycles.

Decomposition:
- Shared bus package: FSM state encodings, slave-frame length constant (3), start-bit value (1), SLAVE_ID_W = 2. The arbiter uses the same constants.
- One natural sub-module: bus_shift_reg, a DATA_WIDTH PISO/SIPO shift register with load/shift/count, instantiated once for both directions.

Test Plan:
1. Write, DATA_WIDTH=8:
   - Stimulus: start, rw=1, slave_id=2, wdata_in=0xA5; grant asserted 2 cycles after request.
   - slave_select = 1,0,1; then wdata = 1,0,1,0,0,1,0,1 with wvalid high 8 cycles.
   - done pulses once; request low the following cycle.
2. Read:
   - Stimulus: slave_id=1; slave drives rvalid with rdata bits of 0x3C, with one rvalid gap after bit 3.
   - slave_select = 1,1,0; rdata_out = 0x3C only after the 8th bit; done pulses once.
3. Grant timeout: grant held 0 for 16 cycles -> err pulses on cycle 16; request drops; no slave_select activity; done never asserts.
4. Lost grant: grant deasserted during write bit 4 -> err next cycle, wvalid=0, request=0, FSM returns to IDLE.
5. Reset: reset asserted mid-READ -> all outputs 0 immediately. The prior rdata_out value is cleared to 0. A new start after release works normally.
6. Busy collision: start pulsed while busy -> ignored; latched slave_id/data unchanged; exactly one done.
